// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Holds the PC, issues word fetches to instruction
//   memory under a credit limit and presents {pc, instruction} pairs to the
//   IF/ID register through a valid/ready handshake. A redirect flushes the
//   response buffer and marks every in-flight request for discard.
//
// Parameters
//   RESET_PC  PC of the first fetch after reset
//   DEPTH     response buffer entries; also the cap on outstanding requests
//
// Ports
//   clk             clock, rising edge
//   reset_n         asynchronous active-low reset
//   imem_req        fetch request valid (registered)
//   imem_addr       fetch byte address, word aligned
//   imem_gnt        request accepted this cycle
//   imem_rvalid     in-order response valid
//   imem_rdata      instruction word of the oldest outstanding request
//   redirect_valid  taken branch / jump redirect
//   redirect_pc     new PC, low two bits ignored
//   fetch_valid     buffer head valid toward IF/ID
//   fetch_ready     IF/ID accepts the head entry
//   fetch_pc        PC of the presented instruction
//   fetch_instr     presented instruction
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {BOOT, FETCH} state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] buf_count;

  // PC tags of outstanding requests, oldest at tag_rd.
  logic [31:0]   tag_q [DEPTH];
  logic [PW-1:0] tag_wr;
  logic [PW-1:0] tag_rd;

  // Response buffer holding {pc, instr} pairs for IF/ID.
  logic [31:0]   buf_pc    [DEPTH];
  logic [31:0]   buf_instr [DEPTH];
  logic [PW-1:0] buf_wr;
  logic [PW-1:0] buf_rd;

  logic          issue;
  logic          push;
  logic          pop;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count_next;
  logic [CW:0]   occupancy_next;
  logic          credit_next;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign imem_addr   = pc;
  assign fetch_valid = (buf_count != '0);
  assign fetch_pc    = buf_pc[buf_rd];
  assign fetch_instr = buf_instr[buf_rd];

  always_comb begin
    issue = imem_req & imem_gnt;
    // A response is kept only when nothing is pending discard and no redirect
    // is flushing this cycle; a redirect drops the word arriving with it.
    push  = imem_rvalid & ~redirect_valid & (discard == '0);
    pop   = fetch_valid & fetch_ready & ~redirect_valid;
    outstanding_next = outstanding + CW'(issue) - CW'(imem_rvalid);
    if (redirect_valid)
      count_next = '0;
    else
      count_next = buf_count + CW'(push) - CW'(pop);
    // The request register is computed from next-cycle occupancy, so it equals
    // the credit condition on the values it will be presented with.
    occupancy_next = {1'b0, outstanding_next} + {1'b0, count_next};
    credit_next    = (occupancy_next < (CW + 1)'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      outstanding <= '0;
      discard     <= '0;
      buf_count   <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      case (state)
        BOOT: begin
          state    <= FETCH;
          imem_req <= credit_next;
        end
        FETCH: begin
          state    <= FETCH;
          imem_req <= credit_next;
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase

      if (redirect_valid)
        pc <= redirect_pc & 32'hFFFF_FFFC;
      else if (issue)
        pc <= pc + 32'd4;

      outstanding <= outstanding_next;

      // Every in-flight request after a redirect belongs to the old path,
      // including one granted in the redirect cycle itself.
      if (redirect_valid)
        discard <= outstanding_next;
      else if (imem_rvalid && discard != '0)
        discard <= discard - 1'b1;

      if (issue)
        tag_wr <= ptr_inc(tag_wr);
      if (imem_rvalid)
        tag_rd <= ptr_inc(tag_rd);

      buf_count <= count_next;
      if (redirect_valid) begin
        buf_wr <= buf_rd;
      end else begin
        if (push) begin
          buf_pc[buf_wr]    <= tag_q[tag_rd];
          buf_instr[buf_wr] <= imem_rdata;
          buf_wr            <= ptr_inc(buf_wr);
        end
        if (pop)
          buf_rd <= ptr_inc(buf_rd);
      end
    end
  end

  // Tag storage is pure data; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (issue)
      tag_q[tag_wr] <= pc;
  end

  a_rvalid_with_outstanding : assert property (
    @(posedge clk) disable iff (!reset_n) imem_rvalid |-> (outstanding != '0));

  a_no_push_when_full : assert property (
    @(posedge clk) disable iff (!reset_n) push |-> (buf_count != CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed bench for fetch_unit (RESET_PC=0, DEPTH=2). A per-cycle vector
//   table drives the memory / redirect / ready inputs and lists the outputs
//   expected in that same cycle; instruction words are addr ^ 32'hA5A5_0000.
//   Hand-written sequences cover asynchronous reset mid-burst and a redirect
//   arriving during the boot cycle.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;

  int n_chk  = 0;
  int n_fail = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
    .fetch_instr    (fetch_instr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        rdy;
    logic        rd;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic gnt, input logic rv, input logic [31:0] rdata,
                             input logic rdy, input logic rd, input logic [31:0] rpc,
                             input logic e_req, input logic [31:0] e_addr,
                             input logic e_fv, input logic [31:0] e_pc,
                             input logic [31:0] e_instr);
    vec_t v;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.rdy = rdy; v.rd = rd; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc = e_pc; v.e_instr = e_instr;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    // gnt rv rdata          rdy rd rpc            | req addr          fv pc            instr
    // gnt held low 3 cycles after boot, then steady fetch
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         0,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0000,  1,0,32'h0,         1,32'h0000_0004,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0004,  1,0,32'h0,         0,32'h0000_0008,1,32'h0000_0000,32'hA5A5_0000));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0008,1,32'h0000_0004,32'hA5A5_0004));
    tbl.push_back(V(1,1,32'hA5A5_0008,  1,0,32'h0,         1,32'h0000_000C,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_000C,  1,0,32'h0,         0,32'h0000_0010,1,32'h0000_0008,32'hA5A5_0008));
    // ready low for 6 cycles: buffer fills to 2, request stays low until a pop
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         1,32'h0000_0010,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,1,32'hA5A5_0010,  0,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         0,32'h0000_0014,1,32'h0000_000C,32'hA5A5_000C));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0014,1,32'h0000_0010,32'hA5A5_0010));
    tbl.push_back(V(1,1,32'hA5A5_0014,  1,0,32'h0,         1,32'h0000_0018,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0018,  1,0,32'h0,         0,32'h0000_001C,1,32'h0000_0014,32'hA5A5_0014));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_001C,1,32'h0000_0018,32'hA5A5_0018));
    // two outstanding, redirect to 0x103 (aligned to 0x100), both responses dropped
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_001C,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0020,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          1,1,32'h0000_0103, 0,32'h0000_0024,0,32'h0,0));
    tbl.push_back(V(0,1,32'hA5A5_001C,  1,0,32'h0,         0,32'h0000_0100,0,32'h0,0));
    tbl.push_back(V(0,1,32'hA5A5_0020,  1,0,32'h0,         1,32'h0000_0100,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0100,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0100,  1,0,32'h0,         1,32'h0000_0104,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0104,  1,0,32'h0,         0,32'h0000_0108,1,32'h0000_0100,32'hA5A5_0100));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_0108,1,32'h0000_0104,32'hA5A5_0104));
    // redirect together with a pop and an rvalid
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0108,0,32'h0,0));
    tbl.push_back(V(1,1,32'hA5A5_0108,  1,0,32'h0,         1,32'h0000_010C,0,32'h0,0));
    tbl.push_back(V(0,1,32'hA5A5_010C,  1,1,32'h0000_0200, 0,32'h0000_0110,1,32'h0000_0108,32'hA5A5_0108));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'h0000_0200,0,32'h0,0));
    tbl.push_back(V(0,1,32'hA5A5_0200,  1,0,32'h0,         1,32'h0000_0204,0,32'h0,0));
    tbl.push_back(V(0,0,32'h0,          1,0,32'h0,         1,32'h0000_0204,1,32'h0000_0200,32'hA5A5_0200));
    // PC wrap from 0xFFFF_FFFC to 0
    tbl.push_back(V(0,0,32'h0,          1,1,32'hFFFF_FFFC, 1,32'h0000_0204,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          1,0,32'h0,         1,32'hFFFF_FFFC,0,32'h0,0));
    tbl.push_back(V(0,1,32'h5A5A_FFFC,  1,0,32'h0,         1,32'h0000_0000,0,32'h0,0));
    tbl.push_back(V(1,0,32'h0,          0,0,32'h0,         1,32'h0000_0000,1,32'hFFFF_FFFC,32'h5A5A_FFFC));
    tbl.push_back(V(0,0,32'h0,          0,0,32'h0,         0,32'h0000_0004,1,32'hFFFF_FFFC,32'h5A5A_FFFC));

    reset_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; fetch_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_req",   -1, {31'b0, imem_req},    32'h0);
    chk("reset_addr",  -1, imem_addr,            32'h0);
    chk("reset_valid", -1, {31'b0, fetch_valid}, 32'h0);
    chk("reset_pc",    -1, fetch_pc,             32'h0);
    chk("reset_instr", -1, fetch_instr,          32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      imem_gnt       = tbl[i].gnt;
      imem_rvalid    = tbl[i].rv;
      imem_rdata     = tbl[i].rdata;
      fetch_ready    = tbl[i].rdy;
      redirect_valid = tbl[i].rd;
      redirect_pc    = tbl[i].rpc;
      chk("imem_req",    i, {31'b0, imem_req},    {31'b0, tbl[i].e_req});
      chk("imem_addr",   i, imem_addr,            tbl[i].e_addr);
      chk("fetch_valid", i, {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
      if (tbl[i].e_fv) begin
        chk("fetch_pc",    i, fetch_pc,    tbl[i].e_pc);
        chk("fetch_instr", i, fetch_instr, tbl[i].e_instr);
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle with a full-ish buffer
    // and a request outstanding: outputs must clear without a clock edge.
    imem_gnt = 1'b0; imem_rvalid = 1'b0; fetch_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_req",   100, {31'b0, imem_req},    32'h0);
    chk("async_addr",  100, imem_addr,            32'h0);
    chk("async_valid", 100, {31'b0, fetch_valid}, 32'h0);
    chk("async_pc",    100, fetch_pc,             32'h0);
    chk("async_instr", 100, fetch_instr,          32'h0);
    @(negedge clk);
    @(negedge clk);

    // Redirect during the boot cycle: boot still takes its cycle, new pc used.
    reset_n = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0041;
    chk("boot_req",   101, {31'b0, imem_req},    32'h0);
    chk("boot_valid", 101, {31'b0, fetch_valid}, 32'h0);
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_gnt = 1'b1;
    chk("boot_redir_req",  102, {31'b0, imem_req}, 32'h1);
    chk("boot_redir_addr", 102, imem_addr,         32'h0000_0040);
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("post_boot_addr",  103, imem_addr,         32'h0000_0044);
    chk("post_boot_req",   103, {31'b0, imem_req}, 32'h1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
